// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial framing blocks: receiver FSM state
//   encoding and the line levels of the start and stop bits (also used by
//   the upstream framer).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/serial_rx_out_reg.sv
// serial_rx_out_reg
//   One-entry valid/ready holding register for received words.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_load       a good word is offered this cycle
//     i_data       word offered with i_load
//     i_ready      downstream accepts the held word
//     o_data       held word (stable while o_valid && !i_ready)
//     o_valid      o_data holds an unconsumed word
//     o_overrun    one-cycle pulse: offered word dropped, register full
module serial_rx_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_xfer;

    assign w_xfer = r_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // A word leaving on this edge frees the slot for the new one.
                if (!r_valid || w_xfer) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Framed serial receiver: start bit (1), DATA_W data bits LSB first,
//   optional even-parity bit, stop bit (0). Good words go out on a
//   valid/ready port; bad frames are dropped with a one-cycle error pulse.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     s_in         serial line, idle 0, sampled every rising edge
//     m_data       received word
//     m_valid      m_data holds an unconsumed word
//     m_ready      downstream accepts the word
//     frame_err    one-cycle pulse: stop bit sampled as 1
//     parity_err   one-cycle pulse: parity mismatch
//     overrun      one-cycle pulse: good word dropped, output full
//
//   state  | meaning
//   IDLE   | waiting for a start bit
//   DATA   | shifting data bit r_cnt
//   PARITY | latching the parity bit
//   STOP   | sampling the stop bit and judging the frame
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_in,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_bit;
    logic              r_frame_err;
    logic              r_parity_err;

    logic              w_stop_bad;
    logic              w_par_bad;
    logic              w_word_good;

    assign w_stop_bad  = (s_in != STOP_LVL);
    assign w_par_bad   = PARITY_EN && ((^r_shift) != r_par_bit);
    // Stop error wins over parity error; only one verdict per frame.
    assign w_word_good = (r_state == STOP) && !w_stop_bad && !w_par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_in == START_LVL) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                    end
                end
                DATA: begin
                    r_shift[r_cnt] <= s_in;
                    if (r_cnt == LAST_BIT) begin
                        r_state <= PARITY_EN ? PARITY : STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    r_par_bit <= s_in;
                    r_state   <= STOP;
                end
                STOP: begin
                    r_frame_err  <= w_stop_bad;
                    r_parity_err <= !w_stop_bad && w_par_bad;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    serial_rx_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_word_good),
        .i_data    (r_shift),
        .i_ready   (m_ready),
        .o_data    (m_data),
        .o_valid   (m_valid),
        .o_overrun (overrun)
    );

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       s_in;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] q_data[$];
    int         q_cyc[$];

    serial_frame_rx #(
        .DATA_W    (8),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_in       (s_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: inputs change at the falling edge, so sample 2 ns later.
    always @(negedge clk) begin
        #2;
        if (rst_n && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        s_in = b;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        drive_bit(1'b1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    initial begin
        rst_n   = 1'b0;
        s_in    = 1'b0;
        m_ready = 1'b1;
        #1;
        check("reset m_valid",    {31'd0, m_valid},    32'd0);
        check("reset m_data",     {24'd0, m_data},     32'd0);
        check("reset frame_err",  {31'd0, frame_err},  32'd0);
        check("reset parity_err", {31'd0, parity_err}, 32'd0);
        check("reset overrun",    {31'd0, overrun},    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive_bit(1'b0);

        // Good frame 0xA5, parity 0.
        q_data.delete(); q_cyc.delete();
        send_frame(8'hA5, 1'b0, 1'b0);
        drive_bit(1'b0);
        check("good m_valid",    {31'd0, m_valid},    32'd1);
        check("good m_data",     {24'd0, m_data},     32'hA5);
        check("good frame_err",  {31'd0, frame_err},  32'd0);
        check("good parity_err", {31'd0, parity_err}, 32'd0);
        check("good overrun",    {31'd0, overrun},    32'd0);
        drive_bit(1'b0);
        check("good m_valid drop", {31'd0, m_valid}, 32'd0);
        check("good xfer count", q_data.size(), 32'd1);

        // Bad stop bit: 0x3C, parity 0, stop 1.
        send_frame(8'h3C, 1'b0, 1'b1);
        drive_bit(1'b0);
        check("stop frame_err",  {31'd0, frame_err},  32'd1);
        check("stop parity_err", {31'd0, parity_err}, 32'd0);
        check("stop m_valid",    {31'd0, m_valid},    32'd0);
        drive_bit(1'b0);
        check("stop frame_err pulse", {31'd0, frame_err}, 32'd0);

        // Parity error: 0x01 needs parity 1, send 0.
        send_frame(8'h01, 1'b0, 1'b0);
        drive_bit(1'b0);
        check("par parity_err", {31'd0, parity_err}, 32'd1);
        check("par frame_err",  {31'd0, frame_err},  32'd0);
        check("par m_valid",    {31'd0, m_valid},    32'd0);
        drive_bit(1'b0);
        check("par parity_err pulse", {31'd0, parity_err}, 32'd0);

        // Backpressure: 0x11 then 0x22 back-to-back with m_ready low.
        q_data.delete(); q_cyc.delete();
        m_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        drive_bit(1'b0);
        check("bp overrun", {31'd0, overrun}, 32'd1);
        check("bp m_valid", {31'd0, m_valid}, 32'd1);
        check("bp m_data",  {24'd0, m_data},  32'h11);
        drive_bit(1'b0);
        check("bp overrun pulse", {31'd0, overrun}, 32'd0);
        check("bp m_data hold",   {24'd0, m_data},  32'h11);
        @(negedge clk);
        m_ready = 1'b1;
        drive_bit(1'b0);
        check("bp m_valid drop", {31'd0, m_valid}, 32'd0);
        drive_bit(1'b0);
        check("bp xfer count", q_data.size(), 32'd1);
        if (q_data.size() > 0) check("bp xfer data", {24'd0, q_data[0]}, 32'h11);

        // Reset mid-frame while a word is held.
        m_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0);
        drive_bit(1'b0);
        check("rst pre m_valid", {31'd0, m_valid}, 32'd1);
        check("rst pre m_data",  {24'd0, m_data},  32'h77);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst m_valid", {31'd0, m_valid}, 32'd0);
        check("rst m_data",  {24'd0, m_data},  32'd0);
        @(negedge clk);
        s_in    = 1'b0;
        m_ready = 1'b1;
        rst_n   = 1'b1;
        drive_bit(1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        drive_bit(1'b0);
        check("rst rx m_valid",    {31'd0, m_valid},    32'd1);
        check("rst rx m_data",     {24'd0, m_data},     32'h5A);
        check("rst rx frame_err",  {31'd0, frame_err},  32'd0);
        check("rst rx parity_err", {31'd0, parity_err}, 32'd0);
        drive_bit(1'b0);

        // Zero-gap stream 0x0F then 0xF0.
        q_data.delete(); q_cyc.delete();
        send_frame(8'h0F, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        repeat (3) drive_bit(1'b0);
        check("gap xfer count", q_data.size(), 32'd2);
        if (q_data.size() == 2) begin
            check("gap data0", {24'd0, q_data[0]}, 32'h0F);
            check("gap data1", {24'd0, q_data[1]}, 32'hF0);
            check("gap spacing", q_cyc[1] - q_cyc[0], 32'd11);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver that sits directly downstream of the 4-bit SISO shift register and consumes its `s_out` stream, one bit per clock. It detects a start bit, deserializes a fixed-width LSB-first word, checks optional even parity and the stop bit, and presents each good word on a valid/ready output port. Bad or overflowing frames are dropped and reported by one-cycle error pulses.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `PARITY_EN`, default 1: 1 inserts one even-parity bit between the data and stop bits; 0 means no parity bit.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock; `s_in` is sampled on every edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_in`  in  1  serial line, driven by SISO `s_out`; idle level 0.
- `m_data`  out  DATA_W  received word.
- `m_valid`  out  1  `m_data` holds an unconsumed word.
- `m_ready`  in  1  downstream accepts the word.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 1.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: good word completed while the output register was full and not draining.

## Operation
- Frame format: start bit = 1; DATA_W data bits, LSB first; parity bit if `PARITY_EN` (XOR of the data bits; even parity); stop bit = 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `s_in`=1 moves to DATA and clears the bit counter. `s_in`=0 stays in IDLE.
  - DATA: shifts `s_in` into bit position `cnt`, then increments `cnt`. At `cnt`=DATA_W-1, moves to PARITY if `PARITY_EN`, otherwise to STOP.
  - PARITY: latches the parity bit, then moves to STOP.
  - STOP: evaluates the frame and always returns to IDLE.
- Frame evaluation at the STOP-sampling edge:
  - `s_in`=1: `frame_err` pulses and the word is dropped. This takes priority over a parity error, so only one error pulse fires.
  - Otherwise, parity mismatch: `parity_err` pulses and the word is dropped.
  - Otherwise the word is good.
- Output register and handshake:
  - A transfer occurs on an edge where `m_valid` and `m_ready` are both 1.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
  - A good word loads into the register if it is empty or transferring on the same edge; `m_valid` is then 1. A simultaneous transfer and load is not an overrun.
  - A good word arriving while the register is full and `m_ready`=0 is dropped, `overrun` pulses, and the held word is kept.
- Bit counter width: `$clog2(DATA_W)`. The counter never wraps mid-frame.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0; FSM in IDLE; counter 0.
- Reset mid-frame discards the partial word immediately (asynchronous). Reception resumes with the first start bit after `rst_n` rises.
- Frame length: 2+DATA_W+PARITY_EN cycles (11 at the defaults). If the start bit is sampled at edge 0, the stop bit is sampled at edge DATA_W+1+PARITY_EN.
- `m_valid` and the error pulses are registered at the stop-sampling edge and visible in the following cycle. The pulses last exactly one cycle.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop edge (zero idle cycles).
- After a frame error the FSM is in IDLE with the line at 1, so the next edge is treated as a start bit. This is documented behaviour.

## Structure
- Shared package `serial_pkg` holds:
  - the FSM state enum (`rx_state_t`: IDLE, DATA, PARITY, STOP);
  - constants `START_LVL`=1'b1 and `STOP_LVL`=1'b0, which the future upstream framer also uses.
- One sub-module, `serial_rx_out_reg`: a one-entry valid/ready holding register with load, transfer and overrun-pulse logic. The FSM, shifter and parity checker live in the top module.

## Test plan
All scenarios use `DATA_W`=8, `PARITY_EN`=1.
- Good frame: drive 1, 1,0,1,0,0,1,0,1, 0, 0 with `m_ready`=1 -> `m_valid` high for one cycle after the stop edge, `m_data`=8'hA5, no error pulses.
- Bad stop bit: frame 0x3C with correct parity and stop=1 -> one `frame_err` pulse, no `m_valid`, `parity_err` stays 0.
- Parity error: frame 0x01 with parity=0 -> one `parity_err` pulse, `m_valid` stays 0.
- Backpressure: `m_ready`=0, send 0x11 then 0x22 back-to-back -> `m_data` holds 0x11, `overrun` pulses at the 0x22 stop edge. Raising `m_ready` -> 0x11 is transferred, `m_valid` drops, 0x22 is never presented.
- Reset mid-frame: after the start bit and 4 data bits, pulse `rst_n` low -> all outputs 0 at once. A subsequent full frame 0x5A is received correctly.
- Zero-gap stream: frames 0x0F and 0xF0, the second start bit sampled on the edge right after the first stop edge, `m_ready`=1 -> two `m_valid` cycles 11 cycles apart, data 0x0F then 0xF0.
